axi_mem_slave: RTL and testbench
================================

Name: axi_mem_slave

Overview:
- AXI4 full-protocol responder (slave) backed by an internal register-array memory.
- It is the far-end target for the team's burst master. It accepts INCR/FIXED write and read bursts, applies per-byte strobes, returns B and R responses, and flags out-of-range beats with SLVERR.
- Write and read paths are independent FSMs sharing one memory array.

Parameters:
- S_BASE_ADDR, 32'h40000000, byte address of memory word 0.
- S_AXI_ID_WIDTH, 1, ID width on AW/B/AR/R.
- S_AXI_ADDR_WIDTH, 32, address width.
- S_AXI_DATA_WIDTH, 32, data width; must be 32 or 64.
- MEM_DEPTH, 64, number of data-width words; must be a power of 2.

Ports:
- s_axi_aclk  in  1  clock
- s_axi_aresetn  in  1  reset; asynchronous assert, active-low
- s_axi_awid/awaddr/awlen/awsize/awburst  in  ID/ADDR/8/3/2  write address info
- s_axi_awvalid  in  1 / s_axi_awready  out  1  AW handshake
- s_axi_wdata  in  DATA / s_axi_wstrb  in  DATA/8 / s_axi_wlast  in  1  write data
- s_axi_wvalid  in  1 / s_axi_wready  out  1  W handshake
- s_axi_bid  out  ID / s_axi_bresp  out  2 / s_axi_bvalid  out  1 / s_axi_bready  in  1  write response
- s_axi_arid/araddr/arlen/arsize/arburst  in  ID/ADDR/8/3/2  read address info
- s_axi_arvalid  in  1 / s_axi_arready  out  1  AR handshake
- s_axi_rid  out  ID / s_axi_rdata  out  DATA / s_axi_rresp  out  2 / s_axi_rlast  out  1  read data
- s_axi_rvalid  out  1 / s_axi_rready  in  1  R handshake
- Lock/cache/prot/qos/region inputs are accepted and ignored. Widths come from the shared para.v macros.

Behaviour:
- Reset (async, aresetn=0): all FSMs go to IDLE. awready=wready=bvalid=arready=rvalid=rlast=0; bresp=rresp=0; bid=rid=0; rdata=0. Memory contents are undefined (not reset).
- Address decode: offset = addr - S_BASE_ADDR. Word index = offset >> log2(DATA/8). A beat is in range when offset < MEM_DEPTH*DATA/8. Low address bits below the word size are ignored (aligned-only slave).
- awsize/arsize: any value other than log2(DATA/8) makes the whole burst SLVERR. The burst still completes its full beat count; writes are suppressed and rdata is 0.
- Beat address: INCR adds DATA/8 per beat; FIXED holds the address. Burst type 2'b11 (reserved) is SLVERR for the whole burst.
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. On awvalid, latch id/addr/len/size/burst, clear the beat counter, set awready=0 and wready=1 the next cycle, and go to W_DATA.
  - W_DATA: on each wvalid&&wready, write bytes where wstrb[i]=1 (in-range beats only) and advance the address and counter. A beat with counter==awlen is the last.
  - Last beat: wready=0 next cycle, bvalid=1, bid=latched id, go to W_RESP.
  - wlast protocol check: wlast must be 1 on the last beat and 0 on all others. Any mismatch sets sticky SLVERR for the burst, but the burst still ends on the count.
  - W_RESP: hold bvalid/bid/bresp until bready. On handshake go to W_IDLE (awready=1 next cycle).
  - bresp: 2'b10 if any beat was out-of-range or erroneous, else 2'b00.
- Read FSM R_IDLE -> R_DATA:
  - R_IDLE: arready=1. On arvalid, latch id/addr/len/size/burst and go to R_DATA.
  - R_DATA: rvalid=1 the cycle after the AR handshake, with rdata = mem[word0] registered. rid, rresp (per beat: 2'b10 if out-of-range/error, data 0) and rlast (counter==arlen) are registered alongside.
  - rdata/rresp/rlast must stay stable while rvalid&&!rready.
  - On rvalid&&rready: if not last, load the next beat the next cycle. This gives back-to-back beats at full throughput, with no bubble.
  - After the last beat: rvalid=0, go to R_IDLE.
- Simultaneous write and read to the same word in the same cycle: the read returns old data and the write takes effect afterward.
- Reset asserted mid-burst: immediate return to the reset values above. No response is issued for the aborted burst.
- One outstanding transaction per direction. Further AW/AR requests stall via ready=0.

Optional Feature:
- Macro AXI_WRAP_BURST_EN.
- Defined: awburst/arburst=2'b10 (WRAP) is supported. The len must be 1, 3, 7 or 15; any other len is SLVERR for the whole burst. The address wraps within the aligned (len+1)*DATA/8 byte boundary.
- Undefined: WRAP is treated like the reserved type, i.e. SLVERR on every beat with writes suppressed and rdata 0, with the full beat count still honoured.

Test Plan:
- INCR write, addr 0x40000000, len=15, data 0..15, all strobes -> 16 W beats accepted, bresp=00 and bid match. Then INCR read of the same range -> rdata 0..15, rlast only on beat 15, rresp=00.
- Write 0xAABBCCDD to 0x40000004 with wstrb=4'b0101, then read it -> 0x??BB??DD: bytes 1 and 3 keep their prior value (0x00000001 from test 1, giving 0x00BB00DD).
- Read len=3 with rready toggling 1,0,0,1,... -> rdata/rlast held stable while stalled, 4 beats delivered in order, no beat lost.
- Write starting at the last word (offset MEM_DEPTH*4-4), len=1 -> beat 0 written, beat 1 suppressed, bresp=10. Read of the same range -> beat 1 has rresp=10 and rdata=0.
- Write with wlast asserted on beat 2 of a len=3 burst -> 4 beats still accepted, bresp=10.
- Assert aresetn=0 mid-read (beat 2 of 8) -> rvalid=0 asynchronously. After release arready=1 and a new burst completes normally. With AXI_WRAP_BURST_EN, a WRAP len=3 read at 0x40000008 -> word order 2,3,0,1.

Source files
------------

// File: rtl/axi_mem_slave.sv
// AXI4 responder over an internal word array: INCR/FIXED bursts, byte strobes, SLVERR on bad beats.
// Latency: AW->wready 1 cycle, last W->bvalid 1 cycle, AR->first rvalid 1 cycle, R beats back-to-back.
// Backpressure: one burst per direction; awready/arready stay low until the previous B / last R is taken.
// Optional: define AXI_WRAP_BURST_EN to accept WRAP bursts (len 1/3/7/15); otherwise WRAP is SLVERR.
module axi_mem_slave #(
    parameter logic [31:0] S_BASE_ADDR      = 32'h40000000,
    parameter int          S_AXI_ID_WIDTH   = 1,
    parameter int          S_AXI_ADDR_WIDTH = 32,
    parameter int          S_AXI_DATA_WIDTH = 32,
    parameter int          MEM_DEPTH        = 64
) (
    input  logic                          s_axi_aclk,
    input  logic                          s_axi_aresetn,
    // write address
    input  logic [S_AXI_ID_WIDTH-1:0]     s_axi_awid,
    input  logic [S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                    s_axi_awlen,
    input  logic [2:0]                    s_axi_awsize,
    input  logic [1:0]                    s_axi_awburst,
    input  logic                          s_axi_awlock,
    input  logic [3:0]                    s_axi_awcache,
    input  logic [2:0]                    s_axi_awprot,
    input  logic [3:0]                    s_axi_awqos,
    input  logic [3:0]                    s_axi_awregion,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    // write data
    input  logic [S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                          s_axi_wlast,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    // write response
    output logic [S_AXI_ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    // read address
    input  logic [S_AXI_ID_WIDTH-1:0]     s_axi_arid,
    input  logic [S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                    s_axi_arlen,
    input  logic [2:0]                    s_axi_arsize,
    input  logic [1:0]                    s_axi_arburst,
    input  logic                          s_axi_arlock,
    input  logic [3:0]                    s_axi_arcache,
    input  logic [2:0]                    s_axi_arprot,
    input  logic [3:0]                    s_axi_arqos,
    input  logic [3:0]                    s_axi_arregion,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    // read data
    output logic [S_AXI_ID_WIDTH-1:0]     s_axi_rid,
    output logic [S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rlast,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready
);

    localparam int AW       = S_AXI_ADDR_WIDTH;
    localparam int BYTES    = S_AXI_DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(BYTES);
    localparam int IDX_W    = $clog2(MEM_DEPTH);

    localparam logic [AW-1:0] BASE      = AW'(S_BASE_ADDR);
    localparam logic [AW-1:0] MEM_BYTES = AW'(MEM_DEPTH * BYTES);
    localparam logic [AW-1:0] BEAT      = AW'(BYTES);
    localparam logic [2:0]    SIZE_OK   = 3'(ADDR_LSB);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    // Word storage, deliberately not reset.
    logic [S_AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Offsets below the base wrap to huge unsigned values and so fall out of range.
    function automatic logic in_range(input logic [AW-1:0] addr);
        logic [AW-1:0] off;
        off = addr - BASE;
        return off < MEM_BYTES;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [AW-1:0] addr);
        logic [AW-1:0] off;
        off = (addr - BASE) >> ADDR_LSB;
        return IDX_W'(off);
    endfunction

    // WRAP stepping is present in every build; without the macro such bursts are
    // flagged as errors, so the stepped address is never used to touch memory.
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr,
                                                 input logic [1:0]    burst,
                                                 input logic [7:0]    len);
        logic [AW-1:0] mask;
        logic [AW-1:0] inc;
        mask = ((AW'(len) + AW'(1)) << ADDR_LSB) - AW'(1);
        inc  = addr + BEAT;
        case (burst)
            2'b00:   return addr;
            2'b10:   return (addr & ~mask) | (inc & mask);
            default: return inc;
        endcase
    endfunction

`ifdef AXI_WRAP_BURST_EN
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction
`endif

    // Sideband AXI attributes carry no meaning for this target.
    logic unused_sideband;
    assign unused_sideband = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awregion,
                               s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arregion};

    // ---------------------------------------------------------------- write path
    w_state_t                    w_state, w_next;
    logic [S_AXI_ID_WIDTH-1:0]   w_id_q;
    logic [AW-1:0]               w_addr_q;
    logic [7:0]                  w_len_q;
    logic [7:0]                  w_cnt_q;
    logic [1:0]                  w_burst_q;
    logic                        w_bad_q;
    logic                        w_err_q;
    logic                        aw_bad;
    logic                        aw_hs, w_hs, b_hs;
    logic                        w_last_beat, w_beat_ok, w_beat_err;
    logic [IDX_W-1:0]            w_idx;

    assign aw_hs       = s_axi_awvalid && s_axi_awready;
    assign w_hs        = s_axi_wvalid && s_axi_wready;
    assign b_hs        = s_axi_bvalid && s_axi_bready;
    assign w_last_beat = (w_cnt_q == w_len_q);
    assign w_beat_ok   = !w_bad_q && in_range(w_addr_q);
    assign w_beat_err  = !w_beat_ok || (s_axi_wlast != w_last_beat);
    assign w_idx       = word_idx(w_addr_q);

    // Classify the whole write burst as erroneous from its AW attributes.
    always_comb begin
        aw_bad = (s_axi_awsize != SIZE_OK);
        case (s_axi_awburst)
            2'b00, 2'b01: ;
`ifdef AXI_WRAP_BURST_EN
            2'b10: if (!wrap_len_ok(s_axi_awlen)) aw_bad = 1'b1;
`endif
            default: aw_bad = 1'b1;
        endcase
    end

    // Write FSM state register.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) w_state <= W_IDLE;
        else                w_state <= w_next;
    end

    // Write FSM next state: the burst ends on the beat count, never on wlast.
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && w_last_beat) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Write handshake outputs, burst context and the sticky error behind bresp.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bid     <= '0;
            s_axi_bresp   <= 2'b00;
            w_id_q        <= '0;
            w_addr_q      <= '0;
            w_len_q       <= '0;
            w_cnt_q       <= '0;
            w_burst_q     <= '0;
            w_bad_q       <= 1'b0;
            w_err_q       <= 1'b0;
        end else begin
            s_axi_awready <= (w_next == W_IDLE);
            s_axi_wready  <= (w_next == W_DATA);
            s_axi_bvalid  <= (w_next == W_RESP);
            if (aw_hs) begin
                w_id_q    <= s_axi_awid;
                w_addr_q  <= s_axi_awaddr;
                w_len_q   <= s_axi_awlen;
                w_burst_q <= s_axi_awburst;
                w_cnt_q   <= 8'd0;
                w_bad_q   <= aw_bad;
                w_err_q   <= 1'b0;
            end
            if (w_hs) begin
                w_addr_q <= next_addr(w_addr_q, w_burst_q, w_len_q);
                w_cnt_q  <= w_cnt_q + 8'd1;
                w_err_q  <= w_err_q | w_beat_err;
                if (w_last_beat) begin
                    s_axi_bid   <= w_id_q;
                    s_axi_bresp <= (w_err_q || w_beat_err) ? 2'b10 : 2'b00;
                end
            end
        end
    end

    // Byte-masked memory write for accepted, valid beats.
    always_ff @(posedge s_axi_aclk) begin
        if (w_hs && w_beat_ok) begin
            for (int i = 0; i < BYTES; i++) begin
                if (s_axi_wstrb[i]) mem[w_idx][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
            end
        end
    end

    // ---------------------------------------------------------------- read path
    r_state_t                    r_state, r_next;
    logic [AW-1:0]               r_addr_q;
    logic [7:0]                  r_len_q;
    logic [7:0]                  r_cnt_q;
    logic [1:0]                  r_burst_q;
    logic                        r_bad_q;
    logic                        ar_bad;
    logic                        ar_hs, r_hs, ld_en, ld_bad, ld_ok;
    logic [AW-1:0]               ld_addr;
    logic [7:0]                  ld_cnt, ld_len;
    logic [IDX_W-1:0]            ld_idx;

    assign ar_hs = s_axi_arvalid && s_axi_arready;
    assign r_hs  = s_axi_rvalid && s_axi_rready;
    assign ld_en = ar_hs || (r_hs && !s_axi_rlast);

    // Classify the whole read burst as erroneous from its AR attributes.
    always_comb begin
        ar_bad = (s_axi_arsize != SIZE_OK);
        case (s_axi_arburst)
            2'b00, 2'b01: ;
`ifdef AXI_WRAP_BURST_EN
            2'b10: if (!wrap_len_ok(s_axi_arlen)) ar_bad = 1'b1;
`endif
            default: ar_bad = 1'b1;
        endcase
    end

    // Select the beat to load next: first beat from AR, later beats by stepping.
    always_comb begin
        ld_addr = next_addr(r_addr_q, r_burst_q, r_len_q);
        ld_cnt  = r_cnt_q + 8'd1;
        ld_len  = r_len_q;
        ld_bad  = r_bad_q;
        if (ar_hs) begin
            ld_addr = s_axi_araddr;
            ld_cnt  = 8'd0;
            ld_len  = s_axi_arlen;
            ld_bad  = ar_bad;
        end
        ld_ok  = !ld_bad && in_range(ld_addr);
        ld_idx = word_idx(ld_addr);
    end

    // Read FSM state register.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) r_state <= R_IDLE;
        else                r_state <= r_next;
    end

    // Read FSM next state: leave on the handshake of the last beat.
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (r_hs && s_axi_rlast) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Registered R channel; a beat only changes on load, so it holds while stalled.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rid     <= '0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= 2'b00;
            s_axi_rlast   <= 1'b0;
            r_addr_q      <= '0;
            r_len_q       <= '0;
            r_cnt_q       <= '0;
            r_burst_q     <= '0;
            r_bad_q       <= 1'b0;
        end else begin
            s_axi_arready <= (r_next == R_IDLE);
            s_axi_rvalid  <= (r_next == R_DATA);
            if (ar_hs) begin
                s_axi_rid <= s_axi_arid;
                r_len_q   <= s_axi_arlen;
                r_burst_q <= s_axi_arburst;
                r_bad_q   <= ar_bad;
            end
            if (ld_en) begin
                r_addr_q    <= ld_addr;
                r_cnt_q     <= ld_cnt;
                s_axi_rdata <= ld_ok ? mem[ld_idx] : '0;
                s_axi_rresp <= ld_ok ? 2'b00 : 2'b10;
                s_axi_rlast <= (ld_cnt == ld_len);
            end else if (r_hs) begin
                s_axi_rlast <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Randomised bench for axi_mem_slave: a byte-level reference memory predicts B and R responses.
// Expected responses are queued at issue time; a monitor pops them on each B/R handshake.
// R stability under rready stalls and asynchronous reset behaviour are checked as well.
module tb_axi_mem_slave;

    localparam int          NB    = 4;
    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h40000000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        awid, awvalid, awready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic        bid, bvalid, bready;
    logic [1:0]  bresp;
    logic        arid, arvalid, arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rid, rlast, rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        tie_lock = 1'b0;
    logic [3:0]  tie_4 = 4'h0;
    logic [2:0]  tie_3 = 3'h0;

    axi_mem_slave #(
        .S_BASE_ADDR(BASE), .S_AXI_ID_WIDTH(1), .S_AXI_ADDR_WIDTH(32),
        .S_AXI_DATA_WIDTH(32), .MEM_DEPTH(DEPTH)
    ) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
        .s_axi_awburst(awburst), .s_axi_awlock(tie_lock), .s_axi_awcache(tie_4), .s_axi_awprot(tie_3),
        .s_axi_awqos(tie_4), .s_axi_awregion(tie_4), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
        .s_axi_wready(wready), .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
        .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
        .s_axi_arburst(arburst), .s_axi_arlock(tie_lock), .s_axi_arcache(tie_4), .s_axi_arprot(tie_3),
        .s_axi_arqos(tie_4), .s_axi_arregion(tie_4), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- reference model
    logic [7:0] ref_mem [DEPTH*NB];

    typedef struct packed { logic id; logic [1:0] resp; } b_exp_t;
    typedef struct packed { logic id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;
    b_exp_t bq[$];
    r_exp_t rq[$];

    logic [31:0] wd [256];
    logic [3:0]  ws [256];
    logic        wl [256];

    function automatic bit burst_ok(input logic [2:0] size, input logic [1:0] burst, input int len);
        if (size != 3'd2) return 1'b0;
        if (burst == 2'b00 || burst == 2'b01) return 1'b1;
`ifdef AXI_WRAP_BURST_EN
        if (burst == 2'b10) return (len == 1 || len == 3 || len == 7 || len == 15);
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                              input logic [1:0] burst, input int i);
        logic [31:0] span, lo;
        if (burst == 2'b00) return start;
        if (burst == 2'b10) begin
            span = 32'((len + 1) * NB);
            lo   = start - (start % span);
            return lo + ((start - lo) + 32'(i * NB)) % span;
        end
        return start + 32'(i * NB);
    endfunction

    function automatic bit in_rng(input logic [31:0] a);
        return (a - BASE) < 32'(DEPTH * NB);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    // ---------------------------------------------------------------- ready drivers
    int rmode = 0;   // 0: always ready, 1: pattern 1,0,0,..., 2: random
    int bmode = 0;   // 0: always ready, 1: random
    int cyc   = 0;
    initial begin
        rready = 1'b1;
        bready = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            case (rmode)
                0:       rready = 1'b1;
                1:       rready = (cyc % 3 == 0);
                default: rready = 1'($urandom_range(0, 1));
            endcase
            bready = (bmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // ---------------------------------------------------------------- monitor
    logic        stall_hold = 1'b0;
    logic [35:0] held;
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                stall_hold = 1'b0;
            end else begin
                if (stall_hold) begin
                    check("r_stall_valid", 64'(rvalid), 64'd1);
                    check("r_stall_stable", 64'({rid, rdata, rresp, rlast}), 64'(held));
                    stall_hold = 1'b0;
                end
                if (rvalid && !rready) begin
                    stall_hold = 1'b1;
                    held = {rid, rdata, rresp, rlast};
                end
                if (rvalid && rready) begin
                    if (rq.size() == 0) begin
                        check("r_unexpected_beat", 64'(rvalid), 64'd0);
                    end else begin
                        r_exp_t e;
                        e = rq.pop_front();
                        check("rid", 64'(rid), 64'(e.id));
                        check("rdata", 64'(rdata), 64'(e.data));
                        check("rresp", 64'(rresp), 64'(e.resp));
                        check("rlast", 64'(rlast), 64'(e.last));
                    end
                end
                if (bvalid && bready) begin
                    if (bq.size() == 0) begin
                        check("b_unexpected", 64'(bvalid), 64'd0);
                    end else begin
                        b_exp_t e;
                        e = bq.pop_front();
                        check("bid", 64'(bid), 64'(e.id));
                        check("bresp", 64'(bresp), 64'(e.resp));
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------- stimulus tasks
    task automatic fill_beats(input int len, input bit rand_strb);
        for (int i = 0; i <= len; i++) begin
            wd[i] = $urandom;
            ws[i] = rand_strb ? 4'($urandom_range(0, 15)) : 4'hF;
            wl[i] = (i == len);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                            input logic [1:0] burst, input logic id);
        bit          ok, err;
        logic [31:0] a;
        int          w, n;
        b_exp_t      be;
        ok  = burst_ok(size, burst, len);
        err = !ok;
        for (int i = 0; i <= len; i++) begin
            a = beat_addr(addr, len, burst, i);
            if (wl[i] != (i == len)) err = 1'b1;
            if (!ok || !in_rng(a)) begin
                err = 1'b1;
            end else begin
                w = word_of(a);
                for (int j = 0; j < NB; j++)
                    if (ws[i][j]) ref_mem[w*NB + j] = wd[i][j*8 +: 8];
            end
        end
        be.id   = id;
        be.resp = err ? 2'b10 : 2'b00;
        bq.push_back(be);

        @(negedge clk);
        awid = id; awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 200) begin @(negedge clk); n++; end
        check("aw_handshake", 64'(awready), 64'd1);
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if ($urandom_range(0, 3) == 0) begin wvalid = 1'b0; @(negedge clk); end
            wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = wl[i];
            n = 0;
            while (!wready && n < 200) begin @(negedge clk); n++; end
            check("w_handshake", 64'(wready), 64'd1);
            @(negedge clk);
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        n = 0;
        while (bq.size() != 0 && n < 300) begin @(negedge clk); n++; end
        check("b_drain", 64'(bq.size()), 64'd0);
        bq.delete();
    endtask

    task automatic issue_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                              input logic [1:0] burst, input logic id);
        bit          ok, bok;
        logic [31:0] a, d;
        int          w, n;
        r_exp_t      re;
        bok = burst_ok(size, burst, len);
        for (int i = 0; i <= len; i++) begin
            a  = beat_addr(addr, len, burst, i);
            ok = bok && in_rng(a);
            d  = 32'h0;
            if (ok) begin
                w = word_of(a);
                for (int j = 0; j < NB; j++) d[j*8 +: 8] = ref_mem[w*NB + j];
            end
            re.id   = id;
            re.data = d;
            re.resp = ok ? 2'b00 : 2'b10;
            re.last = (i == len);
            rq.push_back(re);
        end
        @(negedge clk);
        arid = id; araddr = addr; arlen = 8'(len); arsize = size; arburst = burst; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 300) begin @(negedge clk); n++; end
        check("ar_handshake", 64'(arready), 64'd1);
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic wait_r_drain();
        int n;
        n = 0;
        while (rq.size() != 0 && n < 2000) begin @(negedge clk); n++; end
        check("r_drain", 64'(rq.size()), 64'd0);
        rq.delete();
    endtask

    task automatic do_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                           input logic [1:0] burst, input logic id);
        issue_read(addr, len, size, burst, id);
        wait_r_drain();
    endtask

    // ---------------------------------------------------------------- main sequence
    initial begin
        int n;
        awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awvalid = 0;
        wdata = 0; wstrb = 0; wlast = 0; wvalid = 0;
        arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arvalid = 0;

        #12;
        check("rst_awready", 64'(awready), 64'd0);
        check("rst_wready", 64'(wready), 64'd0);
        check("rst_bvalid", 64'(bvalid), 64'd0);
        check("rst_arready", 64'(arready), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_rlast", 64'(rlast), 64'd0);
        check("rst_resp", 64'({bresp, rresp}), 64'd0);
        check("rst_ids", 64'({bid, rid}), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("awready_after_reset", 64'(awready), 64'd1);
        check("arready_after_reset", 64'(arready), 64'd1);

        // whole memory to known contents
        fill_beats(DEPTH - 1, 1'b0);
        do_write(BASE, DEPTH - 1, 3'd2, 2'b01, 1'b0);

        // INCR 16 beats of 0..15, then read back
        for (int i = 0; i < 16; i++) begin wd[i] = 32'(i); ws[i] = 4'hF; wl[i] = (i == 15); end
        do_write(BASE, 15, 3'd2, 2'b01, 1'b1);
        do_read(BASE, 15, 3'd2, 2'b01, 1'b1);

        // partial strobes on word 1
        wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101; wl[0] = 1'b1;
        do_write(BASE + 32'd4, 0, 3'd2, 2'b01, 1'b0);
        do_read(BASE + 32'd4, 0, 3'd2, 2'b01, 1'b0);

        // rready stalls
        rmode = 1;
        do_read(BASE + 32'd8, 3, 3'd2, 2'b01, 1'b1);
        rmode = 0;

        // running off the end of memory
        fill_beats(1, 1'b0);
        do_write(BASE + 32'(DEPTH * NB - 4), 1, 3'd2, 2'b01, 1'b0);
        do_read(BASE + 32'(DEPTH * NB - 4), 1, 3'd2, 2'b01, 1'b1);

        // early wlast
        fill_beats(3, 1'b0);
        wl[2] = 1'b1;
        wl[3] = 1'b0;
        do_write(BASE + 32'd32, 3, 3'd2, 2'b01, 1'b1);
        do_read(BASE + 32'd32, 3, 3'd2, 2'b01, 1'b0);

        // wrong size and FIXED bursts
        fill_beats(2, 1'b0);
        do_write(BASE + 32'd64, 2, 3'd1, 2'b01, 1'b0);
        do_read(BASE + 32'd64, 2, 3'd3, 2'b01, 1'b0);
        fill_beats(3, 1'b1);
        do_write(BASE + 32'd80, 3, 3'd2, 2'b00, 1'b1);
        do_read(BASE + 32'd80, 3, 3'd2, 2'b00, 1'b1);

        // WRAP len=3 at word 2: word order 2,3,0,1 when enabled, SLVERR otherwise
        do_read(BASE + 32'd8, 3, 3'd2, 2'b10, 1'b0);
        fill_beats(7, 1'b0);
        do_write(BASE + 32'd52, 7, 3'd2, 2'b10, 1'b1);
        do_read(BASE + 32'd32, 7, 3'd2, 2'b01, 1'b1);

        // randomised traffic with random backpressure
        rmode = 2;
        bmode = 1;
        for (int t = 0; t < 60; t++) begin
            int          w, len;
            logic [1:0]  burst;
            logic [2:0]  size;
            logic [31:0] a;
            w     = int'($urandom_range(0, DEPTH + 7)) - 4;
            a     = BASE + 32'(w * NB);
            len   = int'($urandom_range(0, 15));
            burst = 2'($urandom_range(0, 3));
            size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 3)) : 3'd2;
            if ($urandom_range(0, 1) == 0) begin
                fill_beats(len, 1'b1);
                if ($urandom_range(0, 9) == 0) begin
                    int k;
                    k = int'($urandom_range(0, len));
                    wl[k] = ~wl[k];
                end
                do_write(a, len, size, burst, 1'($urandom_range(0, 1)));
            end else begin
                do_read(a, len, size, burst, 1'($urandom_range(0, 1)));
            end
        end
        rmode = 0;
        bmode = 0;

        // reset in the middle of an 8-beat read
        issue_read(BASE, 7, 3'd2, 2'b01, 1'b1);
        n = 0;
        while (rq.size() > 6 && n < 200) begin @(negedge clk); n++; end
        check("pre_reset_beats", 64'(rq.size()), 64'd6);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_rvalid", 64'(rvalid), 64'd0);
        check("async_rst_rlast", 64'(rlast), 64'd0);
        check("async_rst_arready", 64'(arready), 64'd0);
        rq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("arready_after_abort", 64'(arready), 64'd1);
        check("rvalid_after_abort", 64'(rvalid), 64'd0);
        fill_beats(7, 1'b0);
        do_write(BASE + 32'd16, 7, 3'd2, 2'b01, 1'b0);
        do_read(BASE + 32'd16, 7, 3'd2, 2'b01, 1'b0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
